// File: rtl/mem_arb_pkg.sv
// Shared types for the two-master RAM arbiter: control states and master ids.
package mem_arb_pkg;
   localparam int NUM_MASTERS = 2;

   typedef enum logic [1:0] {IDLE, OWN0, OWN1} arb_state_t;
   typedef logic [0:0] master_id_t;

   function automatic arb_state_t own_state(master_id_t id);
      return id[0] ? OWN1 : OWN0;
   endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of both requester ports plus the shared RAM port.
// The slave side belongs to the arbiter; the master side drives requests and models the RAM.
interface mem_arbiter_if #(
   parameter int AW = 32,
   parameter int DW = 32
);
   logic          m0_req, m0_lock, m0_wr_en;
   logic [AW-1:0] m0_addr;
   logic [DW-1:0] m0_w_data;
   logic          m0_gnt, m0_r_valid;
   logic [DW-1:0] m0_r_data;

   logic          m1_req, m1_lock, m1_wr_en;
   logic [AW-1:0] m1_addr;
   logic [DW-1:0] m1_w_data;
   logic          m1_gnt, m1_r_valid;
   logic [DW-1:0] m1_r_data;

   logic          ram_wr_en;
   logic [AW-1:0] ram_addr;
   logic [DW-1:0] ram_w_data;
   logic [DW-1:0] ram_r_data;

   modport slave (
      input  m0_req, m0_lock, m0_wr_en, m0_addr, m0_w_data,
      output m0_gnt, m0_r_data, m0_r_valid,
      input  m1_req, m1_lock, m1_wr_en, m1_addr, m1_w_data,
      output m1_gnt, m1_r_data, m1_r_valid,
      output ram_wr_en, ram_addr, ram_w_data,
      input  ram_r_data
   );

   modport master (
      output m0_req, m0_lock, m0_wr_en, m0_addr, m0_w_data,
      input  m0_gnt, m0_r_data, m0_r_valid,
      output m1_req, m1_lock, m1_wr_en, m1_addr, m1_w_data,
      input  m1_gnt, m1_r_data, m1_r_valid,
      input  ram_wr_en, ram_addr, ram_w_data,
      output ram_r_data
   );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one RAM port between the CPU (m0) and a debug/loader (m1),
// with capped locked bursts and read-data valid steering back to the issuing master.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int AW        = 32,
   parameter int DW        = 32,
   parameter int MAX_BURST = 8
) (
   input  logic        clk,
   input  logic        rst_n,
   mem_arbiter_if.slave bus
);
   localparam int BW = (MAX_BURST > 2) ? $clog2(MAX_BURST) : 1;
   localparam logic [BW-1:0] CNT_CAP = BW'(MAX_BURST - 1);

   arb_state_t state_q, state_d;
   master_id_t last_q, last_d;
   master_id_t rd_id_q, rd_id_d;
   logic [BW-1:0] bcnt_q, bcnt_d, cnt_base;
   logic rd_pend_q, rd_pend_d;

   logic [NUM_MASTERS-1:0] req, lock, wr, gnt;
   logic any_gnt;
   master_id_t gnt_id;
   logic [AW-1:0] addr_sel;
   logic [DW-1:0] wdata_sel;

   assign req  = {bus.m1_req,   bus.m0_req};
   assign lock = {bus.m1_lock,  bus.m0_lock};
   assign wr   = {bus.m1_wr_en, bus.m0_wr_en};

   // An owner that stops requesting does not block the other master in the same cycle.
   always_comb begin
      gnt = '0;
      if (rst_n) begin
         if (state_q == OWN0 && req[0])      gnt = 2'b01;
         else if (state_q == OWN1 && req[1]) gnt = 2'b10;
         else if (req == 2'b11)              gnt = last_q[0] ? 2'b01 : 2'b10;
         else                                gnt = req;
      end
   end

   assign any_gnt = |gnt;
   assign gnt_id  = master_id_t'(gnt[1]);

   // A new owner starts counting from zero even if the other master left a partial burst.
   always_comb begin
      state_d   = IDLE;
      last_d    = last_q;
      bcnt_d    = '0;
      cnt_base  = (state_q == own_state(gnt_id)) ? bcnt_q : '0;
      rd_pend_d = any_gnt && !wr[gnt_id];
      rd_id_d   = gnt_id;
      if (any_gnt) begin
         last_d = gnt_id;
         if (lock[gnt_id] && cnt_base != CNT_CAP) begin
            state_d = own_state(gnt_id);
            bcnt_d  = cnt_base + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         last_q    <= 1'b1;
         bcnt_q    <= '0;
         rd_pend_q <= 1'b0;
         rd_id_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         last_q    <= last_d;
         bcnt_q    <= bcnt_d;
         rd_pend_q <= rd_pend_d;
         rd_id_q   <= rd_id_d;
      end
   end

   assign addr_sel  = gnt[1] ? bus.m1_addr   : bus.m0_addr;
   assign wdata_sel = gnt[1] ? bus.m1_w_data : bus.m0_w_data;

   assign bus.ram_addr   = addr_sel;
   assign bus.ram_w_data = wdata_sel;
   assign bus.ram_wr_en  = any_gnt && wr[gnt_id];

   assign bus.m0_gnt     = gnt[0];
   assign bus.m1_gnt     = gnt[1];
   assign bus.m0_r_data  = bus.ram_r_data;
   assign bus.m1_r_data  = bus.ram_r_data;
   assign bus.m0_r_valid = rd_pend_q && (rd_id_q == 1'b0);
   assign bus.m1_r_valid = rd_pend_q && (rd_id_q == 1'b1);
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-master arbiter that sits between the CPU's data port and `rw_ram`, so that a second requester can share the single RAM port with the CPU. That second requester is a debug/loader engine that reads and writes RAM while the program runs. Each cycle it grants at most one master, in round-robin order. It supports short locked bursts with a hard length cap, and it routes the registered read data back to the master that issued the read.

## Interface
Parameters:
- `AW`, 32, address width
- `DW`, 32, data width
- `MAX_BURST`, 8, maximum consecutive grants to one locked master (≥2)

Ports:
- `clk`  in  1  system clock; all state updates on rising edge
- `rst_n`  in  1  reset, asynchronous assert, active-low
- `m0_req`  in  1  CPU requests one RAM access this cycle
- `m0_lock`  in  1  CPU asks to keep the grant next cycle
- `m0_wr_en`  in  1  1 = write, 0 = read
- `m0_addr`  in  AW  byte address
- `m0_w_data`  in  DW  write data
- `m0_gnt`  out  1  access accepted this cycle
- `m0_r_data`  out  DW  read data
- `m0_r_valid`  out  1  `m0_r_data` valid (one-cycle pulse)
- `m1_req`, `m1_lock`, `m1_wr_en`, `m1_addr`, `m1_w_data`, `m1_gnt`, `m1_r_data`, `m1_r_valid`: the same signals for the debug/loader master
- `ram_wr_en`  out  1  RAM write strobe
- `ram_addr`  out  AW  RAM address
- `ram_w_data`  out  DW  RAM write data
- `ram_r_data`  in  DW  RAM read data, valid one cycle after the address

## Operation
- **State machine.** Control state `IDLE`, `OWN0`, `OWN1` lives in the registers `state`, `last` (last granted master) and `bcnt` (burst counter).
- **Grant is combinational** from the `req` inputs and the registered state. A request is accepted in the same cycle `gnt` is high. A master holds `req` and its address/data stable until it sees `gnt`.
- **IDLE:**
  - Only one master requesting: that master is granted.
  - Both requesting: the master ≠ `last` is granted.
- **Entering or staying in OWNx.**
  - On a granted cycle with `mx_lock`=1, the next state is `OWNx`.
  - On every consecutive granted cycle in `OWNx`, `bcnt` increments.
- **In OWNx:**
  - Master x gets the grant whenever it requests, and the other master is blocked.
  - A cycle with `mx_req`=0, or a granted cycle with `mx_lock`=0, returns the state to `IDLE`.
- **Burst cap.**
  - When `bcnt` reaches `MAX_BURST`-1 on a granted cycle, the state is forced to `IDLE` regardless of lock.
  - `last` = x is set, so a pending other master wins the next cycle.
- **Counter reset.** `bcnt` clears whenever the state enters `IDLE`.
- **Mux.** `ram_addr`/`ram_w_data` come from the granted master, or from m0 when nobody is granted. `ram_wr_en` = granted master's `wr_en` & `gnt`, and is never high without a grant.
- **Read return.**
  - A granted read registers `rd_pend` = 1 and `rd_id` = x.
  - Next cycle: `mx_r_valid` = 1 and `mx_r_data` = `ram_r_data`.
  - Both `r_data` outputs carry `ram_r_data` unconditionally. Only `r_valid` is steered.
- **Writes** complete in the grant cycle and produce no `r_valid`.

## Timing
- **Reset values:** `state`=`IDLE`, `last`=1 (m0 wins the first tie), `bcnt`=0, `rd_pend`=0. All `gnt`, `r_valid` and `ram_wr_en` = 0 while `rst_n`=0.
- **Read latency:** 1 cycle from grant to `r_valid`.
- **Throughput:** one access per cycle; back-to-back grants are allowed to either master.
- **Same cycle:** a read's `r_valid` and a new grant may coincide.
- **Same master:** the read-return register updates every cycle.
- **Reset mid-burst or with a read pending:** state, counter and pending read are discarded, and no `r_valid` is emitted after reset.
- **Lock with no other requester:** after the cap the owner is granted again in `IDLE`, with no idle gap.

## Structure
- Shared package `mem_arb_pkg`: enum `arb_state_t {IDLE, OWN0, OWN1}`, `typedef logic [0:0] master_id_t`, constant `NUM_MASTERS = 2`.
- Single module, no sub-modules. Grant logic is an `always_comb`. `state`/`last`/`bcnt`/`rd_pend`/`rd_id` are in one `always_ff` with async reset.

## Test plan
- **Single master.** Only m1 reads 0x00000010 (RAM word 0xDEADBEEF) → `m1_gnt`=1 in the same cycle; `m1_r_valid`=1 with 0xDEADBEEF next cycle; `m0_r_valid` stays 0.
- **Round-robin ties.** Both request continuously, no lock → grants alternate m0, m1, m0, m1, starting with m0 after reset.
- **Locked burst with cap.** Both request; m1 holds `lock`=1 with `MAX_BURST`=8 → m1 is granted exactly 8 consecutive cycles, then m0 is granted in cycle 9.
- **Write routing.** m0 write 0x00000004 ← 0x12345678 while m1 is blocked → `ram_wr_en`=1 one cycle with the m0 address/data. A following m1 read of 0x4 returns 0x12345678.
- **Reset mid-read.** Assert `rst_n`=0 in the cycle after granting an m0 read → `m0_r_valid` stays 0 through and after reset; the next tie grants m0.
- **Lock release.** m0 locked, then drops `req` for one cycle → state returns to `IDLE`; a pending m1 is granted in that same cycle.
